fir_ctrl: RTL and testbench

Control and output-buffer stage for the serial FIR datapath `DP`. The block accepts one input sample per filter pass through a valid/ready handshake and sequences `DP` over LENGTH multiply-accumulate cycles. It drives the shift, count, accumulator-enable, accumulator-clear and reset strobes, and watches `dp_rollBack`. It captures the final sum from `dp_out` into a one-entry output buffer, which it presents downstream with a valid/ready handshake.

---
 rtl/fir_ctrl.sv | 140 ++++++++++++++
 tb/tb_fir_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ctrl.sv
// fir_ctrl: control FSM and one-entry output buffer for the serial FIR datapath DP.
// Optional watchdog on CALC length enabled by defining FIR_CTRL_WATCHDOG_EN.
module fir_ctrl #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 100
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [WIDTH-1:0]     in_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic signed [2*WIDTH+5:0]   out_data,
    input  logic                        out_ready,
    output logic                        busy,
    output logic signed [WIDTH-1:0]     dp_in,
    output logic                        dp_rst,
    output logic                        dp_shift_enb,
    output logic                        dp_count_enb,
    output logic                        register_enb,
    output logic                        resetReg,
`ifdef FIR_CTRL_WATCHDOG_EN
    output logic                        err,
`endif
    input  logic                        dp_rollBack,
    input  logic signed [2*WIDTH+5:0]   dp_out
);

    typedef enum logic [1:0] {RST_HOLD, IDLE, CALC} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_out_valid;
    logic signed [2*WIDTH+5:0]  r_out_data;
    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_capture;
    logic                       w_busy;
    logic                       w_dp_rst;
    logic                       w_count_enb;
    logic                       w_register_enb;
`ifdef FIR_CTRL_WATCHDOG_EN
    localparam int CW = $clog2(LENGTH + 2);
    logic [CW-1:0]              r_cnt;
    logic                       r_err;
    logic                       w_timeout;
`endif

    assign dp_in        = in_data;
    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign busy         = w_busy;
    assign dp_rst       = w_dp_rst;
    assign dp_shift_enb = w_accept;
    assign resetReg     = w_accept;
    assign dp_count_enb = w_count_enb;
    assign register_enb = w_register_enb;
`ifdef FIR_CTRL_WATCHDOG_EN
    assign err          = r_err;
`endif

    // Next-state and strobe decode from the registered state and the three handshake/status inputs.
    always_comb begin
        w_next         = r_state;
        w_in_ready     = 1'b0;
        w_accept       = 1'b0;
        w_capture      = 1'b0;
        w_busy         = 1'b0;
        w_dp_rst       = 1'b0;
        w_count_enb    = 1'b0;
        w_register_enb = 1'b0;
`ifdef FIR_CTRL_WATCHDOG_EN
        w_timeout      = 1'b0;
`endif
        case (r_state)
            RST_HOLD: begin
                w_dp_rst = 1'b1;
                w_next   = IDLE;
            end
            IDLE: begin
                w_in_ready = !r_out_valid || out_ready;
                w_accept   = in_valid && w_in_ready;
                w_next     = w_accept ? CALC : IDLE;
            end
            CALC: begin
                w_busy         = 1'b1;
                w_count_enb    = 1'b1;
                w_register_enb = !dp_rollBack;
                w_capture      = dp_rollBack;
`ifdef FIR_CTRL_WATCHDOG_EN
                w_timeout      = !dp_rollBack && (r_cnt == CW'(LENGTH + 1));
                w_next         = dp_rollBack ? IDLE : (w_timeout ? RST_HOLD : CALC);
`else
                w_next         = dp_rollBack ? IDLE : CALC;
`endif
            end
            default: w_next = RST_HOLD;
        endcase
    end

    // State register; reset parks in RST_HOLD so dp_rst covers reset plus one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= RST_HOLD;
        else
            r_state <= w_next;
    end

    // One-entry output buffer: load on the rollBack cycle, empty on a downstream handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= dp_out;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef FIR_CTRL_WATCHDOG_EN
    // Watchdog: r_cnt holds the 1-based index of the current CALC cycle; err is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept)
                r_cnt <= CW'(1);
            else if (r_state == CALC)
                r_cnt <= r_cnt + 1'b1;
            if (w_timeout)
                r_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: directed scoreboard bench for fir_ctrl driving a behavioural serial FIR datapath.
module tb_fir_ctrl;

    localparam int WIDTH  = 8;
    localparam int LENGTH = 100;
    localparam int OW     = 2*WIDTH + 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_data = '0;
    logic              out_ready = 1'b0;
    logic              in_ready, out_valid, busy;
    logic [OW-1:0]     out_data, dp_out;
    logic [WIDTH-1:0]  dp_in;
    logic              dp_rst, dp_shift_enb, dp_count_enb, register_enb, resetReg, dp_rollBack;
`ifdef FIR_CTRL_WATCHDOG_EN
    logic              err;
`endif

    fir_ctrl #(.WIDTH(WIDTH), .LENGTH(LENGTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .dp_in(dp_in), .dp_rst(dp_rst),
        .dp_shift_enb(dp_shift_enb), .dp_count_enb(dp_count_enb),
        .register_enb(register_enb), .resetReg(resetReg),
`ifdef FIR_CTRL_WATCHDOG_EN
        .err(err),
`endif
        .dp_rollBack(dp_rollBack), .dp_out(dp_out)
    );

    always #5 clk = ~clk;

    function automatic int coef_of(int i);
        return (i * 37) % 61 - 30;
    endfunction

    // Behavioural DP: register file, tap pointer, accumulator and combinational adder.
    int   regs [LENGTH];
    int   ptr = 0;
    int   acc = 0;
    logic kill_roll = 1'b0;

    always @(posedge clk) begin
        if (dp_rst) begin
            for (int i = 0; i < LENGTH; i++) regs[i] <= 0;
            ptr <= 0;
            acc <= 0;
        end else begin
            if (dp_shift_enb) begin
                regs[0] <= $signed(dp_in);
                for (int i = 1; i < LENGTH; i++) regs[i] <= regs[i-1];
            end
            if (dp_count_enb) ptr <= (ptr == LENGTH-1) ? 0 : ptr + 1;
            if (resetReg) acc <= 0;
            else if (register_enb) acc <= acc + regs[ptr] * coef_of(ptr);
        end
    end

    always_comb dp_out = OW'(acc + regs[ptr] * coef_of(ptr));
    assign dp_rollBack = (ptr == LENGTH-1) && !kill_roll;

    // Scoreboard state and reference history.
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            n_acc = 0;
    int            last_acc_cyc = 0;
    int            hist [LENGTH];
    logic [OW-1:0] q_exp [$];
    int            q_cyc [$];
    logic          prev_ov = 1'b0;
    logic [OW-1:0] roll_val = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < LENGTH; i++) hist[i] = 0;
        q_exp.delete();
        q_cyc.delete();
    endtask

    task automatic step();
        int s;
        @(negedge clk);
        if (busy && dp_rollBack) roll_val = dp_out;
        if (out_valid && !prev_ov) begin
            if (q_cyc.size() == 0) chk("spurious_out_valid", 32'(out_valid), 0);
            else chk("latency", cyc - q_cyc[0], LENGTH + 1);
        end
        if (out_valid && out_ready) begin
            if (q_exp.size() == 0) chk("spurious_drain", 32'(out_valid), 0);
            else begin
                chk("result", 32'(out_data), 32'(q_exp.pop_front()));
                chk("rollback_sum", 32'(out_data), 32'(roll_val));
                void'(q_cyc.pop_front());
            end
        end
        if (in_valid && in_ready) begin
            for (int i = LENGTH-1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = $signed(in_data);
            s = 0;
            for (int i = 0; i < LENGTH; i++) s += hist[i] * coef_of(i);
            q_exp.push_back(OW'(s));
            q_cyc.push_back(cyc);
            last_acc_cyc = cyc;
            n_acc++;
        end
        prev_ov = out_valid;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ov(string tag);
        int n = 0;
        while (!out_valid && n < 300) begin
            step();
            n++;
        end
        chk(tag, 32'(out_valid), 1);
    endtask

    task automatic wait_empty(string tag);
        int n = 0;
        while (q_exp.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        chk(tag, q_exp.size(), 0);
    endtask

    initial begin
        int start, prev_acc, n;
        clear_model();
        // reset release
        #1;
        step();
        chk("rst_dp_rst", 32'(dp_rst), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_strobes", 32'({dp_shift_enb, dp_count_enb, register_enb, resetReg}), 0);
`ifdef FIR_CTRL_WATCHDOG_EN
        chk("rst_err", 32'(err), 0);
`endif
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("hold_dp_rst", 32'(dp_rst), 1);
        chk("hold_in_ready", 32'(in_ready), 0);
        step();
        chk("idle_dp_rst", 32'(dp_rst), 0);
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_out_valid", 32'(out_valid), 0);

        // single pass
        in_data = 8'h05;
        in_valid = 1'b1;
        #1;
        chk("accept_strobes", 32'({dp_shift_enb, resetReg, busy}), 32'b110);
        chk("dp_in_copy", 32'(dp_in), 32'(in_data));
        step();
        in_valid = 1'b0;
        #1;
        chk("calc_busy", 32'(busy), 1);
        chk("calc_in_ready", 32'(in_ready), 0);
        chk("calc_strobes", 32'({dp_count_enb, register_enb, dp_shift_enb, resetReg}), 32'b1100);
        wait_ov("single_out_valid");

        // back-pressure, then drain and accept in the same cycle
        in_data = 8'hFD;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_data", 32'(out_data), 32'(q_exp[0]));
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 1);
        start = n_acc;
        step();
        chk("bp_drain_accept", n_acc, start + 1);
        out_ready = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("bp_drained", 32'(out_valid), 0);
        chk("bp_busy", 32'(busy), 1);
        wait_ov("bp_out_valid");
        out_ready = 1'b1;
        step();

        // streaming, 5 samples
        in_valid = 1'b1;
        prev_acc = 0;
        for (int k = 0; k < 5; k++) begin
            in_data = WIDTH'(k * 29 - 60);
            start = n_acc;
            n = 0;
            while (n_acc == start && n < 300) begin
                step();
                n++;
            end
            chk("stream_accept", n_acc, start + 1);
            if (k > 0) chk("stream_spacing", last_acc_cyc - prev_acc, LENGTH + 1);
            prev_acc = last_acc_cyc;
        end
        in_valid = 1'b0;
        wait_empty("stream_results");

        // reset in the middle of a pass
        in_data = 8'h07;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (49) step();
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("mid_rst_dp_rst", 32'(dp_rst), 1);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("mid_hold_dp_rst", 32'(dp_rst), 1);
        step();
        chk("mid_idle_dp_rst", 32'(dp_rst), 0);
        chk("mid_idle_in_ready", 32'(in_ready), 1);
        in_data = 8'h09;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_empty("post_reset_result");

`ifdef FIR_CTRL_WATCHDOG_EN
        // watchdog timeout
        in_data = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        kill_roll = 1'b1;
        n = 0;
        while (!err && n < 300) begin
            step();
            n++;
        end
        chk("wd_err", 32'(err), 1);
        chk("wd_err_cycle", cyc - last_acc_cyc, LENGTH + 2);
        chk("wd_dp_rst", 32'(dp_rst), 1);
        chk("wd_no_result", 32'(out_valid), 0);
        clear_model();
        kill_roll = 1'b0;
        step();
        chk("wd_idle_in_ready", 32'(in_ready), 1);
        chk("wd_err_sticky", 32'(err), 1);
        rst_n = 1'b0;
        #1;
        chk("wd_err_cleared", 32'(err), 0);
        step();
        rst_n = 1'b1;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
